// File: rtl/x_dl_stats.sv
// x_dl_stats: decodes delay-line thermometer snapshots into an edge position,
// flags bubbles, and gathers min/max/mean/bubble-count over a batch of
// 2^P_LOG2_N samples. Results leave as four bytes on a valid/accept handshake.
module x_dl_stats #(
    parameter int unsigned P_DL_W   = 32,
    parameter int unsigned P_LOG2_N = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_go,
    input  logic              i_sample,
    input  logic [P_DL_W-1:0] i_dl,
    output logic              o_busy,
    output logic              o_valid,
    input  logic              i_accept,
    output logic [7:0]        o_data
);

    // Edge position spans 0..P_DL_W inclusive.
    localparam int unsigned PosW  = $clog2(P_DL_W + 1);
    // A full batch of maximum positions fits without overflow.
    localparam int unsigned SumW  = PosW + P_LOG2_N;
    localparam int unsigned CntW  = (P_LOG2_N == 0) ? 1 : P_LOG2_N;
    localparam int unsigned NSamp = 1 << P_LOG2_N;
    localparam logic [CntW-1:0] LastCnt = CntW'(NSamp - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StSend
    } state_e;

    state_e          state_q, state_d;
    logic            busy_q, busy_d;
    logic [7:0]      min_q, min_d;
    logic [7:0]      max_q, max_d;
    logic [SumW-1:0] sum_q, sum_d;
    logic [7:0]      bcnt_q, bcnt_d;
    logic [CntW-1:0] scnt_q, scnt_d;
    logic [1:0]      idx_q, idx_d;

    logic [PosW-1:0] pos_c;
    logic [7:0]      pos8_c;
    logic            bubble_c;
    logic            run_c;
    logic [7:0]      mean_c;

    // Thermometer decode: length of the run of ones from bit0, and any stray
    // one beyond the first zero.
    always_comb begin
        pos_c    = '0;
        bubble_c = 1'b0;
        run_c    = 1'b1;
        for (int i = 0; i < int'(P_DL_W); i++) begin
            if (run_c) begin
                if (i_dl[i]) begin
                    pos_c = PosW'(i + 1);
                end else begin
                    run_c = 1'b0;
                end
            end else if (i_dl[i]) begin
                bubble_c = 1'b1;
            end
        end
        pos8_c = 8'(pos_c);
    end

    // Batch control and accumulator next-state.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        sum_d   = sum_q;
        bcnt_d  = bcnt_q;
        scnt_d  = scnt_q;
        idx_d   = idx_q;

        case (state_q)
            StIdle: begin
                // Samples in IDLE, even alongside i_go, are not counted.
                if (i_go) begin
                    state_d = StAcc;
                    min_d   = 8'hFF;
                    max_d   = 8'h00;
                    sum_d   = '0;
                    bcnt_d  = 8'h00;
                    scnt_d  = '0;
                    idx_d   = 2'd0;
                end
            end
            StAcc: begin
                if (i_sample) begin
                    if (pos8_c < min_q) begin
                        min_d = pos8_c;
                    end
                    if (pos8_c > max_q) begin
                        max_d = pos8_c;
                    end
                    sum_d = sum_q + SumW'(pos_c);
                    if (bubble_c && (bcnt_q != 8'hFF)) begin
                        bcnt_d = bcnt_q + 8'd1;
                    end
                    scnt_d = scnt_q + CntW'(1);
                    if (scnt_q == LastCnt) begin
                        state_d = StSend;
                        idx_d   = 2'd0;
                    end
                end
            end
            StSend: begin
                if (i_accept) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and accumulator registers; reset has priority over everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            min_q   <= 8'h00;
            max_q   <= 8'h00;
            sum_q   <= '0;
            bcnt_q  <= 8'h00;
            scnt_q  <= '0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            min_q   <= min_d;
            max_q   <= max_d;
            sum_q   <= sum_d;
            bcnt_q  <= bcnt_d;
            scnt_q  <= scnt_d;
            idx_q   <= idx_d;
        end
    end

    // Result byte selection; the stream is quiet outside SEND.
    always_comb begin
        mean_c  = 8'(sum_q >> P_LOG2_N);
        o_valid = (state_q == StSend);
        o_busy  = busy_q;
        o_data  = 8'h00;
        if (state_q == StSend) begin
            case (idx_q)
                2'd0:    o_data = min_q;
                2'd1:    o_data = max_q;
                2'd2:    o_data = mean_c;
                default: o_data = bcnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_x_dl_stats.sv
// Self-checking bench for x_dl_stats with a 32-tap line and 4-sample batches.
module tb_x_dl_stats;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        sample;
    logic        accept;
    logic [31:0] dl;
    logic        busy;
    logic        valid;
    logic [7:0]  data;

    int tests = 0;
    int fails = 0;

    logic [31:0] smp[N];
    int          gap[N];
    logic [7:0]  got[4];
    bit          got_ok[4];
    logic [7:0]  exp_b[4];
    bit          lat_valid;

    x_dl_stats #(
        .P_DL_W  (32),
        .P_LOG2_N(2)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_go    (go),
        .i_sample(sample),
        .i_dl    (dl),
        .o_busy  (busy),
        .o_valid (valid),
        .i_accept(accept),
        .o_data  (data)
    );

    always #5 clk = ~clk;

    // Reference: statistics straight from the decode rules.
    task automatic model();
        int mn = 255;
        int mx = 0;
        int sm = 0;
        int bc = 0;
        for (int i = 0; i < N; i++) begin
            int p = 0;
            while (p < 32 && smp[i][p]) p++;
            if (p < mn) mn = p;
            if (p > mx) mx = p;
            sm += p;
            if (({32'h0, smp[i]} >> p) != 64'h0) bc++;
        end
        exp_b[0] = 8'(mn);
        exp_b[1] = 8'(mx);
        exp_b[2] = 8'(sm / N);
        exp_b[3] = 8'((bc > 255) ? 255 : bc);
    endtask

    task automatic recv(output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b = 8'h00;
        accept = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            if (valid === 1'b1) begin
                b = data;
                ok = 1'b1;
            end
            @(negedge clk);
        end
        accept = 1'b0;
    endtask

    task automatic run_batch(input bit go_with_sample);
        go = 1'b1;
        sample = go_with_sample;
        dl = 32'h0;
        @(negedge clk);
        go = 1'b0;
        sample = 1'b0;
        for (int i = 0; i < N; i++) begin
            repeat (gap[i]) @(negedge clk);
            sample = 1'b1;
            dl = smp[i];
            @(negedge clk);
            sample = 1'b0;
        end
        lat_valid = valid;
        for (int b = 0; b < 4; b++) recv(got[b], got_ok[b]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        go = 1'b1;
        sample = 1'b1;
        dl = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got %b required 0", busy);
        end
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b required 0", valid);
        end
        tests++;
        if (data !== 8'h00) begin
            fails++;
            $display("FAIL reset_data: got %02h required 00", data);
        end
        rst = 1'b0;
        go = 1'b0;
        sample = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] req[4] = '{8'h08, 8'h08, 8'h08, 8'h00};
        smp = '{32'hFF, 32'hFF, 32'hFF, 32'hFF};
        gap = '{0, 0, 0, 0};
        run_batch(1'b0);
        tests++;
        if (lat_valid !== 1'b1) begin
            fails++;
            $display("FAIL basic_latency: o_valid %b after last sample, required 1", lat_valid);
        end
        for (int b = 0; b < 4; b++) begin
            tests++;
            if (!got_ok[b] || got[b] !== req[b]) begin
                fails++;
                $display("FAIL basic_byte%0d: got %02h (seen=%0d) required %02h",
                         b, got[b], got_ok[b], req[b]);
            end
        end
        tests++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_done: busy=%b valid=%b required 0/0", busy, valid);
        end
    endtask

    task automatic test_mixed();
        logic [7:0] req[4] = '{8'h00, 8'h20, 8'h0D, 8'h00};
        smp = '{32'h0000_000F, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        gap = '{0, 0, 0, 0};
        run_batch(1'b0);
        for (int b = 0; b < 4; b++) begin
            tests++;
            if (!got_ok[b] || got[b] !== req[b]) begin
                fails++;
                $display("FAIL mixed_byte%0d: got %02h (seen=%0d) required %02h",
                         b, got[b], got_ok[b], req[b]);
            end
        end
    endtask

    task automatic test_bubble();
        logic [7:0] req[4] = '{8'h03, 8'h03, 8'h03, 8'h02};
        smp = '{32'h0000_00F7, 32'h0000_0007, 32'h0000_00F7, 32'h0000_0007};
        gap = '{0, 1, 0, 0};
        run_batch(1'b0);
        for (int b = 0; b < 4; b++) begin
            tests++;
            if (!got_ok[b] || got[b] !== req[b]) begin
                fails++;
                $display("FAIL bubble_byte%0d: got %02h (seen=%0d) required %02h",
                         b, got[b], got_ok[b], req[b]);
            end
        end
    endtask

    task automatic test_backpressure();
        int hs = 0;
        smp = '{32'h0000_0001, 32'h0000_03FF, 32'h0000_00F7, 32'h0000_0000};
        model();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < N; i++) begin
            sample = 1'b1;
            dl = smp[i];
            @(negedge clk);
            sample = 1'b0;
        end
        for (int b = 0; b < 4; b++) begin
            accept = 1'b0;
            for (int k = 0; k < 5; k++) begin
                tests++;
                if (valid !== 1'b1 || data !== exp_b[b]) begin
                    fails++;
                    $display("FAIL bp_hold%0d_%0d: valid=%b data=%02h required 1/%02h",
                             b, k, valid, data, exp_b[b]);
                end
                go = (b == 1 && k == 2);
                @(negedge clk);
                go = 1'b0;
            end
            accept = 1'b1;
            tests++;
            if (valid !== 1'b1 || data !== exp_b[b]) begin
                fails++;
                $display("FAIL bp_take%0d: valid=%b data=%02h required 1/%02h",
                         b, valid, data, exp_b[b]);
            end
            if (valid === 1'b1) hs++;
            @(negedge clk);
            accept = 1'b0;
        end
        accept = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (valid === 1'b1) hs++;
            @(negedge clk);
        end
        accept = 1'b0;
        tests++;
        if (hs != 4) begin
            fails++;
            $display("FAIL bp_handshakes: got %0d required 4", hs);
        end
        tests++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_idle: busy=%b valid=%b required 0/0", busy, valid);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] req[4] = '{8'h05, 8'h08, 8'h06, 8'h00};
        // A bubbly pos-0 sample in IDLE would corrupt min and bcnt if counted.
        sample = 1'b1;
        dl = 32'h0000_0002;
        @(negedge clk);
        sample = 1'b0;
        smp = '{32'h0000_003F, 32'h0000_00FF, 32'h0000_001F, 32'h0000_007F};
        gap = '{1, 3, 0, 2};
        run_batch(1'b1);
        for (int b = 0; b < 4; b++) begin
            tests++;
            if (!got_ok[b] || got[b] !== req[b]) begin
                fails++;
                $display("FAIL gaps_byte%0d: got %02h (seen=%0d) required %02h",
                         b, got[b], got_ok[b], req[b]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] req[4] = '{8'h03, 8'h04, 8'h03, 8'h00};
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        sample = 1'b1;
        dl = 32'h0000_0000;
        @(negedge clk);
        dl = 32'hFFFF_FFFF;
        @(negedge clk);
        sample = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (busy !== 1'b0 || valid !== 1'b0 || data !== 8'h00) begin
            fails++;
            $display("FAIL rstmid_state: busy=%b valid=%b data=%02h required 0/0/00",
                     busy, valid, data);
        end
        smp = '{32'h7, 32'hF, 32'h7, 32'hF};
        gap = '{0, 0, 2, 0};
        run_batch(1'b0);
        for (int b = 0; b < 4; b++) begin
            tests++;
            if (!got_ok[b] || got[b] !== req[b]) begin
                fails++;
                $display("FAIL rstmid_byte%0d: got %02h (seen=%0d) required %02h",
                         b, got[b], got_ok[b], req[b]);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < N; i++) begin
                int p = $urandom_range(0, 32);
                logic [31:0] v;
                v = (p == 32) ? 32'hFFFF_FFFF : ((32'h1 << p) - 32'h1);
                if (p < 31 && $urandom_range(0, 2) == 0) v = v | ($urandom << (p + 1));
                smp[i] = v;
                gap[i] = $urandom_range(0, 3);
            end
            model();
            run_batch($urandom_range(0, 1) == 1);
            tests++;
            if (lat_valid !== 1'b1) begin
                fails++;
                $display("FAIL rand%0d_latency: o_valid %b required 1", t, lat_valid);
            end
            for (int b = 0; b < 4; b++) begin
                tests++;
                if (!got_ok[b] || got[b] !== exp_b[b]) begin
                    fails++;
                    $display("FAIL rand%0d_byte%0d: got %02h (seen=%0d) required %02h",
                             t, b, got[b], got_ok[b], exp_b[b]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        go = 1'b0;
        sample = 1'b0;
        accept = 1'b0;
        dl = 32'h0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_mixed();
        test_bubble();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
